// File: rtl/map_mem_arb_pkg.sv
// Shared request/state types for the mapper memory arbiter.
// Latency and backpressure: none, types only.
package map_mem_pkg;

    localparam int REQ_AW = 21;

    typedef enum logic [1:0] {
        K_PRG = 2'd0,
        K_SRM = 2'd1,
        K_CHR = 2'd2
    } req_kind_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } req_op_t;

    typedef struct packed {
        req_kind_t         kind;
        req_op_t           op;
        logic [REQ_AW-1:0] addr;
        logic [7:0]        data;
    } mem_req_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } arb_st_t;

endpackage

// File: rtl/map_mem_arb_if.sv
// Mapper channel + unified SRAM bus bundle; slave side is the arbiter.
// Latency: wires only; backpressure: none (the SRAM is a fixed-timing slave).
interface map_mem_arb_if #(
    parameter int PRG_AW = 19,
    parameter int CHR_AW = 17,
    parameter int SRM_AW = 13,
    parameter int MEM_AW = 21
);
    logic              prg_ce, prg_oe, prg_we;
    logic [PRG_AW-1:0] prg_addr;
    logic [7:0]        prg_dati;
    logic              srm_ce, srm_oe, srm_we;
    logic [SRM_AW-1:0] srm_addr;
    logic [7:0]        srm_dati;
    logic              chr_ce, chr_oe, chr_we;
    logic [CHR_AW-1:0] chr_addr;
    logic [7:0]        chr_dati;
    logic [7:0]        prg_do, srm_do, chr_do;
    logic [MEM_AW-1:0] mem_addr;
    logic [7:0]        mem_dout;
    logic [7:0]        mem_din;
    logic              mem_ce_n, mem_oe_n, mem_we_n;

    modport slave (
        input  prg_ce, prg_oe, prg_we, prg_addr, prg_dati,
        input  srm_ce, srm_oe, srm_we, srm_addr, srm_dati,
        input  chr_ce, chr_oe, chr_we, chr_addr, chr_dati,
        input  mem_din,
        output prg_do, srm_do, chr_do,
        output mem_addr, mem_dout, mem_ce_n, mem_oe_n, mem_we_n
    );

    modport master (
        output prg_ce, prg_oe, prg_we, prg_addr, prg_dati,
        output srm_ce, srm_oe, srm_we, srm_addr, srm_dati,
        output chr_ce, chr_oe, chr_we, chr_addr, chr_dati,
        output mem_din,
        input  prg_do, srm_do, chr_do,
        input  mem_addr, mem_dout, mem_ce_n, mem_oe_n, mem_we_n
    );
endinterface

// File: rtl/map_mem_arb_edge_sync.sv
// Two-flop synchroniser plus an edge-detect flop; rise/fall pulse one clk wide.
// Latency: pulse visible 2 clk edges after the raw edge, consumed on the 3rd; no backpressure.
module edge_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);
    logic [2:0] sync_q;
    logic [2:0] sync_d;

    assign sync_d = {sync_q[1:0], d_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {3{RST_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rise_o = sync_q[1] & ~sync_q[2];
    assign fall_o = ~sync_q[1] & sync_q[2];
endmodule

// File: rtl/map_mem_arb.sv
// Serialises PRG/SRM/CHR mapper channels onto one async SRAM, PPU side first.
// Latency: idle read -> *_do after 1+ACC_CYC clk; backpressure: none, one-deep slots overwrite and flag ovr.
module map_mem_arb
    import map_mem_pkg::*;
#(
    parameter int                PRG_AW   = 19,
    parameter int                CHR_AW   = 17,
    parameter int                SRM_AW   = 13,
    parameter int                MEM_AW   = 21,
    parameter logic [MEM_AW-1:0] PRG_BASE = 21'h000000,
    parameter logic [MEM_AW-1:0] CHR_BASE = 21'h080000,
    parameter logic [MEM_AW-1:0] SRM_BASE = 21'h0A0000,
    parameter int                ACC_CYC  = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cpu_m2,
    input  logic         ppu_oe_n,
    input  logic         ppu_we_n,
    map_mem_arb_if.slave bus,
    output logic         busy,
    output logic         ovr
);
    localparam int              CW   = $clog2(ACC_CYC);
    localparam logic [CW-1:0]   LAST = CW'(ACC_CYC - 1);

    logic m2_rise, m2_fall, oe_fall, we_rise, oe_rise, we_fall;

    edge_sync #(.RST_VAL(1'b0)) u_sync_m2 (
        .clk(clk), .rst_n(rst_n), .d_i(cpu_m2), .rise_o(m2_rise), .fall_o(m2_fall));
    edge_sync #(.RST_VAL(1'b1)) u_sync_oe (
        .clk(clk), .rst_n(rst_n), .d_i(ppu_oe_n), .rise_o(oe_rise), .fall_o(oe_fall));
    edge_sync #(.RST_VAL(1'b1)) u_sync_we (
        .clk(clk), .rst_n(rst_n), .d_i(ppu_we_n), .rise_o(we_rise), .fall_o(we_fall));

    logic unused_edges;
    assign unused_edges = oe_rise | we_fall;

    mem_req_t  cpu_new, ppu_new, cpu_q, ppu_q, cpu_cand, ppu_cand, gnt_req;
    logic      cpu_new_vld, ppu_new_vld, cpu_vld_q, ppu_vld_q;
    logic      grant_cpu, grant_ppu;
    arb_st_t   st_q;
    logic [CW-1:0] cnt_q;
    req_kind_t cur_kind_q;
    req_op_t   cur_op_q;
    logic [MEM_AW-1:0] mem_addr_q;
    logic [7:0]  mem_dout_q, prg_do_q, srm_do_q, chr_do_q;
    logic        ce_n_q, oe_n_q, we_n_q, busy_q, ovr_q;

    function automatic logic [MEM_AW-1:0] base_of(input req_kind_t k);
        case (k)
            K_SRM:   return SRM_BASE;
            K_CHR:   return CHR_BASE;
            default: return PRG_BASE;
        endcase
    endfunction

    // CPU side: save-RAM decode wins over PRG; the target's oe/we gates the event.
    always_comb begin
        cpu_new     = '0;
        cpu_new_vld = 1'b0;
        if (m2_rise || m2_fall) begin
            cpu_new.op = m2_rise ? OP_RD : OP_WR;
            if (bus.srm_ce) begin
                cpu_new.kind = K_SRM;
                cpu_new.addr = {{(MEM_AW-SRM_AW){1'b0}}, bus.srm_addr};
                cpu_new.data = bus.srm_dati;
                cpu_new_vld  = m2_rise ? bus.srm_oe : bus.srm_we;
            end else if (bus.prg_ce) begin
                cpu_new.kind = K_PRG;
                cpu_new.addr = {{(MEM_AW-PRG_AW){1'b0}}, bus.prg_addr};
                cpu_new.data = bus.prg_dati;
                cpu_new_vld  = m2_rise ? bus.prg_oe : bus.prg_we;
            end
        end
    end

    always_comb begin
        ppu_new     = '0;
        ppu_new_vld = 1'b0;
        if (bus.chr_ce && (oe_fall || we_rise)) begin
            ppu_new.kind = K_CHR;
            ppu_new.op   = oe_fall ? OP_RD : OP_WR;
            ppu_new.addr = {{(MEM_AW-CHR_AW){1'b0}}, bus.chr_addr};
            ppu_new.data = bus.chr_dati;
            ppu_new_vld  = oe_fall ? bus.chr_oe : bus.chr_we;
        end
    end

    // A pending slot is older than a same-cycle event, so it is served first.
    assign ppu_cand  = ppu_vld_q ? ppu_q : ppu_new;
    assign cpu_cand  = cpu_vld_q ? cpu_q : cpu_new;
    assign grant_ppu = (st_q == ST_IDLE) && (ppu_vld_q || ppu_new_vld);
    assign grant_cpu = (st_q == ST_IDLE) && !grant_ppu && (cpu_vld_q || cpu_new_vld);
    assign gnt_req   = grant_ppu ? ppu_cand : cpu_cand;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_q     <= '0;
            ppu_q     <= '0;
            cpu_vld_q <= 1'b0;
            ppu_vld_q <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            if (ppu_new_vld) begin
                if (grant_ppu && !ppu_vld_q) begin
                    ppu_vld_q <= 1'b0;
                end else begin
                    ppu_q     <= ppu_new;
                    ppu_vld_q <= 1'b1;
                    if (ppu_vld_q && !grant_ppu) ovr_q <= 1'b1;
                end
            end else if (grant_ppu) begin
                ppu_vld_q <= 1'b0;
            end

            if (cpu_new_vld) begin
                if (grant_cpu && !cpu_vld_q) begin
                    cpu_vld_q <= 1'b0;
                end else begin
                    cpu_q     <= cpu_new;
                    cpu_vld_q <= 1'b1;
                    if (cpu_vld_q && !grant_cpu) ovr_q <= 1'b1;
                end
            end else if (grant_cpu) begin
                cpu_vld_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q       <= ST_IDLE;
            cnt_q      <= '0;
            cur_kind_q <= K_PRG;
            cur_op_q   <= OP_RD;
            mem_addr_q <= '0;
            mem_dout_q <= '0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            prg_do_q   <= 8'hFF;
            srm_do_q   <= 8'hFF;
            chr_do_q   <= 8'hFF;
        end else begin
            case (st_q)
                ST_IDLE: begin
                    if (grant_ppu || grant_cpu) begin
                        st_q       <= ST_ACCESS;
                        cnt_q      <= '0;
                        cur_kind_q <= gnt_req.kind;
                        cur_op_q   <= gnt_req.op;
                        mem_addr_q <= base_of(gnt_req.kind) + gnt_req.addr;
                        if (gnt_req.op == OP_WR) mem_dout_q <= gnt_req.data;
                        ce_n_q     <= 1'b0;
                        oe_n_q     <= (gnt_req.op != OP_RD);
                        we_n_q     <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                ST_ACCESS: begin
                    if (cnt_q == LAST) begin
                        st_q   <= ST_DONE;
                        ce_n_q <= 1'b1;
                        oe_n_q <= 1'b1;
                        we_n_q <= 1'b1;
                        if (cur_op_q == OP_RD) begin
                            case (cur_kind_q)
                                K_SRM:   srm_do_q <= bus.mem_din;
                                K_CHR:   chr_do_q <= bus.mem_din;
                                default: prg_do_q <= bus.mem_din;
                            endcase
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        // Write strobe trails the address by one cycle of setup.
                        if (cur_op_q == OP_WR) we_n_q <= 1'b0;
                    end
                end
                ST_DONE: begin
                    st_q   <= ST_IDLE;
                    busy_q <= 1'b0;
                end
                default: st_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_dout = mem_dout_q;
    assign bus.mem_ce_n = ce_n_q;
    assign bus.mem_oe_n = oe_n_q;
    assign bus.mem_we_n = we_n_q;
    assign bus.prg_do   = prg_do_q;
    assign bus.srm_do   = srm_do_q;
    assign bus.chr_do   = chr_do_q;
    assign busy         = busy_q;
    assign ovr          = ovr_q;
endmodule
